l1_l2_arbiter: RTL and testbench

//  Shares the single L2/memory port between the L1 I-cache and L1 D-cache miss paths.

---
 rtl/l1_l2_arbiter_if.sv | 47 ++++
 rtl/l1_l2_arbiter.sv | 107 ++++++++++
 tb/tb_l1_l2_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/l1_l2_arbiter_if.sv
// Bundle between the two L1 miss paths, the shared arbiter and the L2 port.
// The arbiter sits on the slave modport, the L1/L2 environment on master.
interface l1_l2_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic              l1i_arbi_read;
    logic [ADDR_W-1:0] l1i_arbi_addr;
    logic              l1i_arbi_resp;
    logic [LINE_W-1:0] l1i_arbi_rdata;

    logic              l1d_arbi_read;
    logic              l1d_arbi_write;
    logic [ADDR_W-1:0] l1d_arbi_addr;
    logic [LINE_W-1:0] l1d_arbi_wdata;
    logic              l1d_arbi_resp;
    logic [LINE_W-1:0] l1d_arbi_rdata;

    logic              arbi_l2_read;
    logic              arbi_l2_write;
    logic [ADDR_W-1:0] arbi_l2_addr;
    logic [LINE_W-1:0] arbi_l2_wdata;
    logic              l2_arbi_resp;
    logic [LINE_W-1:0] l2_arbi_rdata;

    modport slave (
        input  l1i_arbi_read, l1i_arbi_addr,
        input  l1d_arbi_read, l1d_arbi_write,
        input  l1d_arbi_addr, l1d_arbi_wdata,
        input  l2_arbi_resp, l2_arbi_rdata,
        output l1i_arbi_resp, l1i_arbi_rdata,
        output l1d_arbi_resp, l1d_arbi_rdata,
        output arbi_l2_read, arbi_l2_write,
        output arbi_l2_addr, arbi_l2_wdata
    );

    modport master (
        output l1i_arbi_read, l1i_arbi_addr,
        output l1d_arbi_read, l1d_arbi_write,
        output l1d_arbi_addr, l1d_arbi_wdata,
        output l2_arbi_resp, l2_arbi_rdata,
        input  l1i_arbi_resp, l1i_arbi_rdata,
        input  l1d_arbi_resp, l1d_arbi_rdata,
        input  arbi_l2_read, arbi_l2_write,
        input  arbi_l2_addr, arbi_l2_wdata
    );
endinterface

// File: rtl/l1_l2_arbiter.sv
// Shares the single L2 port between the L1 I-cache and D-cache miss paths,
// latching the granted request and routing the L2 response back to it.
module l1_l2_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic            clk,
    input  logic            rst,
    l1_l2_arbiter_if.slave  bus,
    output logic            arbi_conflict
);

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } state_e;

    state_e            state_q, state_d;
    logic              last_d_q, last_d_d;
    logic              op_wr_q, op_wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;

    logic req_i;
    logic req_d;
    logic grant_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            last_d_q <= 1'b1;
            op_wr_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            op_wr_q  <= op_wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    // On a tie, D wins only if I was the last tie winner
    assign req_i   = bus.l1i_arbi_read;
    assign req_d   = bus.l1d_arbi_read | bus.l1d_arbi_write;
    assign grant_d = req_d & (~req_i | ~last_d_q);

    always_comb begin
        state_d            = state_q;
        last_d_d           = last_d_q;
        op_wr_d            = op_wr_q;
        addr_d             = addr_q;
        wdata_d            = wdata_q;
        arbi_conflict      = 1'b0;
        bus.arbi_l2_read   = 1'b0;
        bus.arbi_l2_write  = 1'b0;
        bus.arbi_l2_addr   = '0;
        bus.arbi_l2_wdata  = '0;
        bus.l1i_arbi_resp  = 1'b0;
        bus.l1i_arbi_rdata = '0;
        bus.l1d_arbi_resp  = 1'b0;
        bus.l1d_arbi_rdata = '0;

        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    if (req_i && req_d) begin
                        arbi_conflict = 1'b1;
                        last_d_d      = grant_d;
                    end
                    // Write-back wins over a simultaneous D read
                    if (grant_d) begin
                        state_d = SERVE_D;
                        op_wr_d = bus.l1d_arbi_write;
                        addr_d  = bus.l1d_arbi_addr;
                        wdata_d = bus.l1d_arbi_wdata;
                    end else if (req_i) begin
                        state_d = SERVE_I;
                        op_wr_d = 1'b0;
                        addr_d  = bus.l1i_arbi_addr;
                        wdata_d = '0;
                    end
                end
                SERVE_I, SERVE_D: begin
                    bus.arbi_l2_read  = ~op_wr_q;
                    bus.arbi_l2_write = op_wr_q;
                    bus.arbi_l2_addr  = addr_q;
                    bus.arbi_l2_wdata = wdata_q;
                    if (state_q == SERVE_I) begin
                        bus.l1i_arbi_resp  = bus.l2_arbi_resp;
                        bus.l1i_arbi_rdata = bus.l2_arbi_rdata;
                    end else begin
                        bus.l1d_arbi_resp  = bus.l2_arbi_resp;
                        bus.l1d_arbi_rdata = bus.l2_arbi_rdata;
                    end
                    if (bus.l2_arbi_resp) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// Scoreboard bench for l1_l2_arbiter: expected L2 transactions are queued
// as requests are raised and checked when the arbiter issues them.
module tb_l1_l2_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;

    typedef struct {
        bit          d;
        bit          wr;
        logic [31:0] addr;
        logic [LW-1:0] wdata;
    } txn_t;

    logic clk = 1'b0;
    logic rst;
    logic conflict;
    int   errors = 0;
    int   checks = 0;
    txn_t exp_q[$];

    l1_l2_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

    l1_l2_arbiter #(
        .ADDR_W(AW),
        .LINE_W(LW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .arbi_conflict(conflict)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LW-1:0] obs,
                       input logic [LW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_rd"}, bus.arbi_l2_read, 0);
        chk({tag, "_wr"}, bus.arbi_l2_write, 0);
        chk({tag, "_addr"}, bus.arbi_l2_addr, 0);
        chk({tag, "_iresp"}, bus.l1i_arbi_resp, 0);
        chk({tag, "_dresp"}, bus.l1d_arbi_resp, 0);
        chk({tag, "_irdata"}, bus.l1i_arbi_rdata, 0);
        chk({tag, "_drdata"}, bus.l1d_arbi_rdata, 0);
    endtask

    task automatic push(input bit d, input bit wr, input logic [31:0] a,
                        input logic [LW-1:0] w);
        txn_t t;
        t.d = d;
        t.wr = wr;
        t.addr = a;
        t.wdata = w;
        exp_q.push_back(t);
    endtask

    function automatic logic [LW-1:0] rnd_line();
        logic [LW-1:0] v;
        for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        idle_chk("reset");
        chk("reset_conflict", conflict, 0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Entered at posedge+1 with the next cycle an IDLE cycle
    task automatic serve(input int lat, input bit rearm,
                         input logic [31:0] naddr, input logic [31:0] chg);
        txn_t e;
        logic [LW-1:0] rd;
        bit exp_cf;
        exp_cf = bus.l1i_arbi_read &
                 (bus.l1d_arbi_read | bus.l1d_arbi_write);
        @(negedge clk);
        chk("idle_conflict", conflict, exp_cf);
        idle_chk("idle");
        if (exp_q.size() == 0) begin
            chk("queue_empty", 1, 0);
            return;
        end
        e = exp_q.pop_front();
        rd = rnd_line();
        @(negedge clk);
        for (int k = 1; k <= lat; k++) begin
            if (k > 1) begin
                @(posedge clk);
                #1;
                if (k == lat) begin
                    bus.l2_arbi_resp = 1'b1;
                    bus.l2_arbi_rdata = rd;
                end
                if (k == 2 && chg != 0) bus.l1d_arbi_addr = chg;
                @(negedge clk);
            end
            chk("l2_read", bus.arbi_l2_read, !e.wr);
            chk("l2_write", bus.arbi_l2_write, e.wr);
            chk("l2_addr", bus.arbi_l2_addr, e.addr);
            if (e.wr) chk("l2_wdata", bus.arbi_l2_wdata, e.wdata);
            chk("serve_conflict", conflict, 0);
            if (k < lat) begin
                chk("early_iresp", bus.l1i_arbi_resp, 0);
                chk("early_dresp", bus.l1d_arbi_resp, 0);
            end else begin
                chk("iresp", bus.l1i_arbi_resp, !e.d);
                chk("dresp", bus.l1d_arbi_resp, e.d);
                chk("irdata", bus.l1i_arbi_rdata, e.d ? '0 : rd);
                chk("drdata", bus.l1d_arbi_rdata, e.d ? rd : '0);
            end
        end
        @(posedge clk);
        #1;
        bus.l2_arbi_resp = 1'b0;
        bus.l2_arbi_rdata = '0;
        if (e.d) begin
            if (e.wr) begin
                bus.l1d_arbi_write = 1'b0;
            end else if (rearm) begin
                bus.l1d_arbi_addr = naddr;
                push(1'b1, 1'b0, naddr, '0);
            end else begin
                bus.l1d_arbi_read = 1'b0;
            end
        end else if (rearm) begin
            bus.l1i_arbi_addr = naddr;
            push(1'b0, 1'b0, naddr, '0);
        end else begin
            bus.l1i_arbi_read = 1'b0;
        end
    endtask

    initial begin
        txn_t e;
        logic [LW-1:0] w;
        rst = 1'b1;
        bus.l1i_arbi_read = 1'b0;
        bus.l1i_arbi_addr = '0;
        bus.l1d_arbi_read = 1'b0;
        bus.l1d_arbi_write = 1'b0;
        bus.l1d_arbi_addr = '0;
        bus.l1d_arbi_wdata = '0;
        bus.l2_arbi_resp = 1'b0;
        bus.l2_arbi_rdata = '0;
        do_reset();

        // Lone I read, five-cycle L2 latency
        bus.l1i_arbi_addr = 32'h100;
        bus.l1i_arbi_read = 1'b1;
        push(1'b0, 1'b0, 32'h100, '0);
        serve(5, 1'b0, 0, 0);

        // Tie after reset: I first, then D write-back
        do_reset();
        w = rnd_line();
        bus.l1i_arbi_addr = 32'h200;
        bus.l1i_arbi_read = 1'b1;
        bus.l1d_arbi_addr = 32'h300;
        bus.l1d_arbi_wdata = w;
        bus.l1d_arbi_write = 1'b1;
        push(1'b0, 1'b0, 32'h200, '0);
        push(1'b1, 1'b1, 32'h300, w);
        serve(3, 1'b0, 0, 0);
        serve(4, 1'b0, 0, 0);

        // Persistent ties alternate I,D,I,D
        do_reset();
        bus.l1i_arbi_addr = 32'h600;
        bus.l1i_arbi_read = 1'b1;
        bus.l1d_arbi_addr = 32'h700;
        bus.l1d_arbi_read = 1'b1;
        push(1'b0, 1'b0, 32'h600, '0);
        push(1'b1, 1'b0, 32'h700, '0);
        serve(2, 1'b1, 32'h610, 0);
        serve(3, 1'b1, 32'h710, 0);
        serve(2, 1'b0, 0, 0);
        serve(2, 1'b0, 0, 0);

        // D address moves mid-service; latched address must hold
        bus.l1d_arbi_addr = 32'h400;
        bus.l1d_arbi_read = 1'b1;
        push(1'b1, 1'b0, 32'h400, '0);
        serve(4, 1'b0, 0, 32'hFFF0);

        // D read and write together: write first, read later
        w = rnd_line();
        bus.l1d_arbi_addr = 32'h800;
        bus.l1d_arbi_wdata = w;
        bus.l1d_arbi_read = 1'b1;
        bus.l1d_arbi_write = 1'b1;
        push(1'b1, 1'b1, 32'h800, w);
        push(1'b1, 1'b0, 32'h800, '0);
        serve(3, 1'b0, 0, 0);
        serve(3, 1'b0, 0, 0);

        // Reset during SERVE_I abandons the transaction
        bus.l1i_arbi_addr = 32'h500;
        bus.l1i_arbi_read = 1'b1;
        push(1'b0, 1'b0, 32'h500, '0);
        @(negedge clk);
        idle_chk("pre_rst");
        e = exp_q.pop_front();
        @(negedge clk);
        chk("rst_l2_read", bus.arbi_l2_read, 1);
        chk("rst_l2_addr", bus.arbi_l2_addr, e.addr);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.l1i_arbi_read = 1'b0;
        @(negedge clk);
        idle_chk("in_rst");
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        idle_chk("post_rst");
        @(posedge clk);
        #1;
        bus.l2_arbi_resp = 1'b1;
        bus.l2_arbi_rdata = rnd_line();
        @(negedge clk);
        idle_chk("stale_resp");
        @(posedge clk);
        #1;
        bus.l2_arbi_resp = 1'b0;
        bus.l2_arbi_rdata = '0;

        chk("queue_left", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
